trace_nop_event_sink: RTL and testbench

Synthesizable per-core consumer of the mor1kx execution trace (`mor1kx_trace_exec`) emitted by each compute tile. It shadows GPR r3, decodes the simulation `l.nop K` hooks (putc, report, exit), and buffers the resulting events in a FIFO. Events leave on a valid/ready stream toward the debug/host side. Exit status is latched for system-level termination logic.

---
 rtl/trace_nop_event_sink.sv | 145 ++++++++++++++
 tb/tb_trace_nop_event_sink.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_nop_event_sink.sv
// Per-core consumer of the mor1kx execution trace: shadows r3, decodes l.nop
// simulation hooks (putc/report/exit) and queues them on a valid/ready stream.
module trace_nop_event_sink #(
  parameter int unsigned ID         = 0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trace_valid,
  input  logic [31:0]           trace_insn,
  input  logic                  trace_wben,
  input  logic [4:0]            trace_wbreg,
  input  logic [31:0]           trace_wbdata,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [1:0]            evt_type,
  output logic [31:0]           evt_data,
  output logic [15:0]           evt_id,
  output logic                  terminated,
  output logic [31:0]           exit_code,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    EVT_PUTC   = 2'd0,
    EVT_REPORT = 2'd1,
    EVT_EXIT   = 2'd2
  } evt_type_e;

  logic [31:0]      r3;
  logic [1:0]       mem_type [FIFO_DEPTH];
  logic [31:0]      mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        is_nop;
  logic        push_req;
  logic        push_ok;
  logic        push_drop;
  logic        pop;
  logic        is_exit;
  evt_type_e   push_type;
  logic [31:0] push_data;
  logic        unused_insn_bits;

  assign unused_insn_bits = ^trace_insn[23:16];

  assign is_nop = trace_valid && (trace_insn[31:24] == 8'h15);

  // Hook decode; event generation stops once the core has exited
  always_comb begin
    push_req  = 1'b0;
    is_exit   = 1'b0;
    push_type = EVT_PUTC;
    push_data = r3;
    if (is_nop && !terminated) begin
      unique case (trace_insn[15:0])
        16'h0001: begin
          push_req  = 1'b1;
          is_exit   = 1'b1;
          push_type = EVT_EXIT;
        end
        16'h0002: begin
          push_req  = 1'b1;
          push_type = EVT_REPORT;
        end
        16'h0004: begin
          push_req  = 1'b1;
          push_data = {24'h0, r3[7:0]};
        end
        default: ;
      endcase
    end
  end

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = push_req && ((count != FULL_CNT) || pop);
  assign push_drop = push_req && !push_ok;

  assign evt_type = mem_type[rd_ptr];
  assign evt_data = mem_data[rd_ptr];
  assign evt_id   = 16'(ID);

  // Shadow of GPR r3 as seen by retired write-backs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3 <= '0;
    end else if (trace_valid && trace_wben && (trace_wbreg == 5'd3)) begin
      r3 <= trace_wbdata;
    end
  end

  // Exit latch and drop accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      terminated <= 1'b0;
      exit_code  <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (is_exit) begin
        terminated <= 1'b1;
        exit_code  <= r3;
      end
      if (push_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  // Event FIFO; storage is reset so the head reads zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_type[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_type[wr_ptr] <= push_type;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_nop_event_sink.sv
// Scoreboard bench for trace_nop_event_sink: a queue-based event model is
// fed by the driver and drained by a negedge monitor on each handshake.
module tb_trace_nop_event_sink;

  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] d;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_insn = '0;
  logic        trace_wben = 1'b0;
  logic [4:0]  trace_wbreg = '0;
  logic [31:0] trace_wbdata = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  evt_type;
  logic [31:0] evt_data;
  logic [15:0] evt_id;
  logic        terminated;
  logic [31:0] exit_code;
  logic        overflow;
  logic [15:0] drop_cnt;

  trace_nop_event_sink #(.ID(0), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .trace_valid(trace_valid), .trace_insn(trace_insn), .trace_wben(trace_wben),
    .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_data(evt_data), .evt_id(evt_id), .terminated(terminated),
    .exit_code(exit_code), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  // Reference model state (reflects DUT state after the most recent edge)
  evt_t        exp_q[$];
  logic [31:0] m_r3 = '0;
  logic        m_term = 1'b0;
  logic [31:0] m_code = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;

  // Effects planned for the coming edge
  logic        p_r3_we = 1'b0;
  logic [31:0] p_r3 = '0;
  logic        p_push = 1'b0;
  evt_t        p_evt = '0;
  logic        p_drop = 1'b0;
  logic        p_exit = 1'b0;
  logic [31:0] p_code = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void clear_plan();
    p_r3_we = 1'b0; p_push = 1'b0; p_drop = 1'b0; p_exit = 1'b0;
  endfunction

  function automatic void commit();
    if (p_r3_we) m_r3 = p_r3;
    if (p_push) exp_q.push_back(p_evt);
    if (p_drop) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hffff) m_drop = m_drop + 16'd1;
    end
    if (p_exit) begin
      m_term = 1'b1;
      m_code = p_code;
    end
    clear_plan();
  endfunction

  // Behavioural rules: nops report the pre-edge r3; one slot freed by a same-cycle pop
  function automatic void plan(input logic v, input logic [31:0] insn, input logic we,
                               input logic [4:0] wr, input logic [31:0] wd, input logic rdy);
    logic has;
    clear_plan();
    p_r3_we = v && we && (wr == 5'd3);
    p_r3    = wd;
    has     = 1'b0;
    if (v && insn[31:24] == 8'h15 && !m_term) begin
      case (insn[15:0])
        16'h0001: begin has = 1'b1; p_evt = '{2'd2, m_r3}; p_exit = 1'b1; p_code = m_r3; end
        16'h0002: begin has = 1'b1; p_evt = '{2'd1, m_r3}; end
        16'h0004: begin has = 1'b1; p_evt = '{2'd0, m_r3 & 32'hff}; end
        default: ;
      endcase
    end
    if (has) begin
      if (exp_q.size() < DEPTH || rdy) p_push = 1'b1;
      else p_drop = 1'b1;
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] insn, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd, input logic rdy);
    @(posedge clk);
    if (rst_n) commit();
    #1;
    trace_valid = v; trace_insn = insn; trace_wben = we;
    trace_wbreg = wr; trace_wbdata = wd; evt_ready = rdy;
    plan(v, insn, we, wr, wd, rdy);
  endtask

  function automatic logic [31:0] nop_insn(input logic [15:0] k);
    return {8'h15, 8'($urandom_range(0, 255)), k};
  endfunction

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
  endtask

  task automatic wr_r3(input logic [31:0] v, input logic rdy);
    step(1'b1, 32'he0630000, 1'b1, 5'd3, v, rdy);
  endtask

  task automatic nop(input logic [15:0] k, input logic rdy);
    step(1'b1, nop_insn(k), 1'b0, 5'd0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(evt_valid), 32'd0);
    trace_valid = 1'b0; trace_wben = 1'b0; evt_ready = 1'b0;
    exp_q.delete();
    clear_plan();
    m_r3 = '0; m_term = 1'b0; m_code = '0; m_ovf = 1'b0; m_drop = '0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("reset_evt_type", 32'(evt_type), 32'd0);
    chk("reset_evt_data", evt_data, 32'd0);
    chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("reset_terminated", 32'(terminated), 32'd0);
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      chk("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
      chk("evt_id", 32'(evt_id), 32'd0);
      chk("terminated", 32'(terminated), 32'(m_term));
      chk("exit_code", exit_code, m_code);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (evt_valid && exp_q.size() != 0) begin
        chk("evt_type", 32'(evt_type), 32'(exp_q[0].t));
        chk("evt_data", evt_data, exp_q[0].d);
        if (evt_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  initial begin
    do_reset();

    // putc ordering
    wr_r3(32'h48, 1'b1);
    nop(16'h4, 1'b1);
    wr_r3(32'h69, 1'b1);
    nop(16'h4, 1'b1);
    idle(4, 1'b1);

    // r3 bypass: next-cycle sees new value, same-cycle sees old
    wr_r3(32'h11, 1'b1);
    nop(16'h2, 1'b1);
    step(1'b1, {8'h15, 8'h00, 16'h0002}, 1'b1, 5'd3, 32'h22, 1'b1);
    nop(16'h2, 1'b1);
    idle(4, 1'b1);

    // overflow: 20 putcs with no consumer, then drain exactly 16
    for (int i = 0; i < 20; i++) begin
      wr_r3(32'h100 + 32'(i), 1'b0);
      nop(16'h4, 1'b0);
    end
    idle(1, 1'b0);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
    n_pop = 0;
    idle(24, 1'b1);
    chk("ovf_drain_count", 32'(n_pop), 32'd16);

    // full with simultaneous pop and push
    for (int i = 0; i < 16; i++) begin
      wr_r3(32'hA0 + 32'(i), 1'b0);
      nop(16'h4, 1'b0);
    end
    wr_r3(32'h5A, 1'b0);
    nop(16'h4, 1'b1);
    idle(1, 1'b0);
    chk("full_push_pop_drop", 32'(drop_cnt), 32'd4);
    n_pop = 0;
    idle(24, 1'b1);
    chk("full_push_pop_drain", 32'(n_pop), 32'd16);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [15:0] k;
      logic rdy;
      sel = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 3) != 0);
      if (sel < 30) begin
        step(1'b1, $urandom, 1'b1, 5'($urandom_range(1, 5)), $urandom, rdy);
      end else if (sel < 75) begin
        case ($urandom_range(0, 4))
          0: k = 16'h0002;
          1: k = 16'h0003;
          2: k = 16'h0000;
          default: k = 16'h0004;
        endcase
        if (i > 500 && $urandom_range(0, 19) == 0) k = 16'h0001;
        nop(k, rdy);
      end else begin
        step($urandom_range(0, 1) == 1, $urandom & 32'h00ffffff, 1'b0, 5'd3, $urandom, rdy);
      end
    end
    idle(24, 1'b1);

    // exit then putc is ignored; r3 keeps tracking
    do_reset();
    wr_r3(32'h2A, 1'b1);
    nop(16'h1, 1'b1);
    nop(16'h4, 1'b1);
    wr_r3(32'h77, 1'b1);
    nop(16'h2, 1'b1);
    idle(4, 1'b1);
    chk("exit_terminated", 32'(terminated), 32'd1);
    chk("exit_code_val", exit_code, 32'h2A);

    // async reset with five events queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_r3(32'h30 + 32'(i), 1'b0);
      nop(16'h2, 1'b0);
    end
    idle(1, 1'b0);
    chk("queued_valid", 32'(evt_valid), 32'd1);
    do_reset();
    n_pop = 0;
    idle(6, 1'b1);
    chk("post_reset_no_events", 32'(n_pop), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
